// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC, combinational instruction memory read,
// and a 2-entry {address, word} queue toward the decoder with one-per-cycle throughput.
module fetch_unit #(
   parameter int           N        = 10,
   parameter int           M        = 16,
   parameter logic [N-1:0] RESET_PC = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         fetch_en,
   input  logic         redirect,
   input  logic [N-1:0] redirect_pc,
   output logic [N-1:0] mem_addr,
   input  logic [M-1:0] mem_data,
   output logic         instr_valid,
   output logic [M-1:0] instr,
   output logic [N-1:0] instr_pc,
   input  logic         instr_ready
);

   logic [N-1:0] pc;
   logic [1:0]   count;
   logic [N-1:0] addr0, addr1;
   logic [M-1:0] word0, word1;
   logic         pop, push;

   assign mem_addr    = pc;
   assign instr_valid = (count != 2'd0);
   assign instr       = instr_valid ? word0 : '0;
   assign instr_pc    = instr_valid ? addr0 : '0;

   // A redirect overrides both handshakes; a full queue still accepts a push when it also pops.
   assign pop  = instr_valid && instr_ready && !redirect;
   assign push = fetch_en && !redirect && ((count != 2'd2) || pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc    <= RESET_PC;
         count <= 2'd0;
      end else if (redirect) begin
         pc    <= redirect_pc;
         count <= 2'd0;
      end else begin
         if (push)
            pc <= pc + N'(1);
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Entry 0 is always the head; payload needs no reset because count gates the outputs.
   always_ff @(posedge clk) begin
      if (pop && !push) begin
         addr0 <= addr1;
         word0 <= word1;
      end else if (push) begin
         if (count == 2'd0 || (count == 2'd1 && pop)) begin
            addr0 <= pc;
            word0 <= mem_data;
         end else if (count == 2'd1) begin
            addr1 <= pc;
            word1 <= mem_data;
         end else begin
            addr0 <= addr1;
            word0 <= word1;
            addr1 <= pc;
            word1 <= mem_data;
         end
      end
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter N, default 10, meaning instruction address width in bits.
REQ-002 The block SHALL have parameter M, default 16, meaning instruction word width in bits.
REQ-003 The block SHALL have parameter RESET_PC, default 0, meaning the fetch address loaded at reset.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port fetch_en, input, 1 bit: permits new fetches while high.
REQ-008 The block SHALL have port redirect, input, 1 bit: branch/jump request, flushes the queue.
REQ-009 The block SHALL have port redirect_pc, input, N bits: new fetch address when redirect is high.
REQ-010 The block SHALL have port mem_addr, output, N bits: read address to the instruction memory.
REQ-011 The block SHALL have port mem_data, input, M bits: combinational memory read data for mem_addr.
REQ-012 The block SHALL have port instr_valid, output, 1 bit: the queue head holds a valid instruction.
REQ-013 The block SHALL have port instr, output, M bits: the queue head instruction word.
REQ-014 The block SHALL have port instr_pc, output, N bits: the address of the queue head instruction.
REQ-015 The block SHALL have port instr_ready, input, 1 bit: the consumer accepts the head this cycle.

Function
REQ-016 The block SHALL hold a fetch address register pc and a 2-entry FIFO of {address, word} pairs with a count of 0..2.
REQ-017 The block SHALL drive mem_addr = pc combinationally at all times.
REQ-018 Pop SHALL occur on a rising edge when instr_valid and instr_ready are both high and redirect is low.
REQ-019 Push SHALL occur on a rising edge when fetch_en=1, redirect=0, and (count<2 or pop in the same cycle). The pushed entry SHALL be {pc, mem_data}.
REQ-020 On push, pc SHALL advance to pc+1 modulo 2^N (2^N-1 wraps to 0).
REQ-021 Push and pop in the same cycle SHALL leave count unchanged, including at count=2 (full throughput: one instruction per cycle).
REQ-022 When redirect=1 on a rising edge, the block SHALL set count=0, set pc=redirect_pc, and perform no push and no pop, regardless of fetch_en and instr_ready.
REQ-023 With fetch_en=0, the block SHALL perform no push, hold pc, and still allow pops to drain the queue.
REQ-024 instr_valid SHALL equal (count!=0). Fetch-to-valid latency SHALL be one cycle: an entry pushed at edge k is visible at the head after edge k if the queue was empty.
REQ-025 When count=0, instr and instr_pc SHALL be driven to 0.
REQ-026 When instr_valid=1 and instr_ready=0, instr, instr_pc and instr_valid SHALL remain stable until popped or flushed.
REQ-027 FIFO order SHALL be preserved: entries exit in the order they were pushed.

Reset
REQ-028 While rst_n=0, asynchronously: pc=RESET_PC, count=0, instr_valid=0, instr=0, instr_pc=0, mem_addr=RESET_PC.
REQ-029 A reset asserted mid-operation SHALL discard all queued entries with no partial pop or push.
REQ-030 Fetching SHALL resume on the first rising edge after rst_n deasserts, provided fetch_en=1.

Verification
REQ-031 Reset then fetch_en=1, instr_ready=1, memory word k = 16'h1000+k -> instr_valid rises after the 1st edge; instr_pc=0,1,2,... on consecutive cycles; instr=16'h1000,16'h1001,...
REQ-032 fetch_en=1, instr_ready=0 for 5 cycles -> count saturates at 2, pc=2, head stays instr_pc=0; set instr_ready=1 -> 0,1,2,3 delivered with no gap or duplicate.
REQ-033 Queue full (instr_pc=5, next entry 6), redirect=1 with redirect_pc=10'h200 for one cycle -> next cycle instr_valid=0; cycle after that instr_pc=10'h200.
REQ-034 RESET_PC=10'h3FE, free-running -> instr_pc sequence 3FE, 3FF, 000, 001.
REQ-035 fetch_en dropped with 2 entries queued and instr_ready=1 -> 2 entries drain, then instr_valid=0 and instr=0; pc holds.
REQ-036 rst_n pulsed low between clock edges with queue full -> instr_valid=0 immediately (before the next edge); mem_addr=RESET_PC.
